multiword_adder_seq: RTL and testbench

//  Multi-precision add sequencer: accepts two WORD_CNT*WORD_WIDTH-bit operands plus carry-in

---
 rtl/multiword_adder_seq.sv | 145 ++++++++++++++
 tb/tb_multiword_adder_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// Multi-precision adder that reuses one WORD_WIDTH-bit slice, one word per clock, LSW first.
// Optional signed-overflow output dout_ovf is built only when MWADD_OVF_EN is defined.
module multiword_adder_seq #(
  parameter int WORD_WIDTH = 4,
  parameter int WORD_CNT   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WORD_WIDTH*WORD_CNT-1:0]   din_a,
  input  logic [WORD_WIDTH*WORD_CNT-1:0]   din_b,
  input  logic                             din_ci,
  input  logic                             din_vld,
  output logic                             din_rd,
  output logic [WORD_WIDTH*WORD_CNT-1:0]   dout_s,
  output logic                             dout_co,
`ifdef MWADD_OVF_EN
  output logic                             dout_ovf,
`endif
  output logic                             dout_vld,
  input  logic                             dout_rd
);

  localparam int TW = WORD_WIDTH * WORD_CNT;
  localparam int CW = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORD_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                                  state_q, state_d;
  logic [CW-1:0]                           cnt_q, cnt_d;
  logic                                    carry_q, carry_d;
  logic [WORD_CNT-1:0][WORD_WIDTH-1:0]     a_q, a_d;
  logic [WORD_CNT-1:0][WORD_WIDTH-1:0]     b_q, b_d;
  logic [WORD_CNT-1:0][WORD_WIDTH-1:0]     sum_q, sum_d;
  logic                                    co_q, co_d;
`ifdef MWADD_OVF_EN
  logic                                    ovf_q, ovf_d;
`endif

  logic [WORD_WIDTH:0]                     slice_s;
  logic                                    accept_s;

  assign din_rd   = (state_q == ST_IDLE) & rst_n;
  assign dout_vld = (state_q == ST_DONE);
  assign dout_s   = sum_q;
  assign dout_co  = co_q;
`ifdef MWADD_OVF_EN
  assign dout_ovf = ovf_q;
`endif
  assign accept_s = din_vld & din_rd;

  // Next-state and datapath: the single shared slice adds word cnt_q plus the carry register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef MWADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    slice_s = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{WORD_WIDTH{1'b0}}, carry_q};

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = din_a;
          b_d     = din_b;
          carry_d = din_ci;
          cnt_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
`ifdef MWADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = slice_s[WORD_WIDTH-1:0];
        carry_d      = slice_s[WORD_WIDTH];
        if (cnt_q == LAST_WORD) begin
          co_d    = slice_s[WORD_WIDTH];
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef MWADD_OVF_EN
          // Top word's MSB is the sign of the full-width result.
          ovf_d   = (a_q[WORD_CNT-1][WORD_WIDTH-1] == b_q[WORD_CNT-1][WORD_WIDTH-1]) &
                    (slice_s[WORD_WIDTH-1] != a_q[WORD_CNT-1][WORD_WIDTH-1]);
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (dout_rd) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef MWADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef MWADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq (WORD_WIDTH=4, WORD_CNT=4); overflow checks
// are included when MWADD_OVF_EN is defined.
module tb_multiword_adder_seq;

  localparam int W  = 4;
  localparam int C  = 4;
  localparam int TW = W * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] din_a, din_b;
  logic          din_ci, din_vld, din_rd;
  logic [TW-1:0] dout_s;
  logic          dout_co, dout_vld, dout_rd;
`ifdef MWADD_OVF_EN
  logic          dout_ovf;
`endif

  int checks = 0;
  int errors = 0;

  multiword_adder_seq #(.WORD_WIDTH(W), .WORD_CNT(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_a    (din_a),
    .din_b    (din_b),
    .din_ci   (din_ci),
    .din_vld  (din_vld),
    .din_rd   (din_rd),
    .dout_s   (dout_s),
    .dout_co  (dout_co),
`ifdef MWADD_OVF_EN
    .dout_ovf (dout_ovf),
`endif
    .dout_vld (dout_vld),
    .dout_rd  (dout_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ci,
                       output logic [TW-1:0] s, output logic co, output logic ovf);
    logic [TW:0] full;
    int          ssum;
    full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, ci};
    s    = full[TW-1:0];
    co   = full[TW];
    ssum = int'($signed(a)) + int'($signed(b)) + int'(ci);
    ovf  = (ssum > 32767) || (ssum < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: handshake, latency check, result check, optional back-pressure hold.
  task automatic txn(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic ci,
                     input int hold, input bit vld_during_hold);
    logic [TW-1:0] es;
    logic          eco, eovf;
    int            guard;
    model(a, b, ci, es, eco, eovf);
    guard = 0;
    while (!din_rd && guard < 20) begin
      tick();
      guard++;
    end
    check("din_rd_wait", 32'(din_rd), 32'd1);
    din_a   = a;
    din_b   = b;
    din_ci  = ci;
    din_vld = 1'b1;
    dout_rd = (hold == 0);
    tick();
    din_vld = vld_during_hold;
    din_a   = TW'($urandom);
    din_b   = TW'($urandom);
    din_ci  = 1'($urandom);
    for (int k = 1; k < C; k++) begin
      check("vld_early", 32'(dout_vld), 32'd0);
      tick();
    end
    check("vld_rise", 32'(dout_vld), 32'd0);
    tick();
    check("vld_at_lat", 32'(dout_vld), 32'd1);
    check("sum", 32'(dout_s), 32'(es));
    check("co", 32'(dout_co), 32'(eco));
`ifdef MWADD_OVF_EN
    check("ovf", 32'(dout_ovf), 32'(eovf));
`endif
    for (int d = 0; d < hold; d++) begin
      tick();
      check("hold_vld", 32'(dout_vld), 32'd1);
      check("hold_sum", 32'(dout_s), 32'(es));
      check("hold_co", 32'(dout_co), 32'(eco));
      check("hold_din_rd", 32'(din_rd), 32'd0);
    end
    dout_rd = 1'b1;
    tick();
    din_vld = 1'b0;
    check("vld_drop", 32'(dout_vld), 32'd0);
    check("idle_rd", 32'(din_rd), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    din_a   = '0;
    din_b   = '0;
    din_ci  = 1'b0;
    din_vld = 1'b0;
    dout_rd = 1'b1;

    // Reset for 3 cycles.
    repeat (3) tick();
    check("rst_vld", 32'(dout_vld), 32'd0);
    check("rst_s", 32'(dout_s), 32'd0);
    check("rst_co", 32'(dout_co), 32'd0);
    check("rst_din_rd", 32'(din_rd), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_din_rd", 32'(din_rd), 32'd1);

    // Directed cases.
    txn(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    txn(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    txn(16'h8001, 16'h8001, 1'b0, 5, 1'b1);
`ifdef MWADD_OVF_EN
    txn(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    txn(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    txn(16'h0003, 16'h0004, 1'b0, 0, 1'b0);
`endif

    // Reset after two RUN words discards the transaction.
    din_a   = 16'h5555;
    din_b   = 16'h5555;
    din_ci  = 1'b0;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_s", 32'(dout_s), 32'd0);
    check("mid_rst_rd", 32'(din_rd), 32'd1);
    for (int k = 0; k < C + 2; k++) begin
      check("mid_rst_vld", 32'(dout_vld), 32'd0);
      tick();
    end
    txn(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Randomised transactions with random back-pressure.
    for (int n = 0; n < 24; n++) begin
      txn(TW'($urandom), TW'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
